// File: rtl/lfsr16_arbiter.sv
// Round-robin controller sharing one lfsr16 among NREQ requesters.
// Seeds and warms up the LFSR after reset, then grants one step/seed-write per cycle.
module lfsr16_arbiter #(
  parameter int         NREQ      = 4,
  parameter int         ID_W      = 2,
  parameter logic [4:0] SEED_INIT = 5'b10000,
  parameter int         WARMUP    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wr,
  input  logic [5*NREQ-1:0] seed,
  output logic [NREQ-1:0]   gnt,
  output logic              ready,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [4:0]        rsp_data,
  output logic              lfsr_rst,
  output logic              lfsr_cen,
  output logic              lfsr_wen,
  output logic [4:0]        lfsr_din,
  input  logic [4:0]        lfsr_dout
);

  typedef enum logic [1:0] {
    S_INIT_WR = 2'd0,
    S_WARMUP  = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            sel_found;
  logic [ID_W-1:0] sel_idx;
  logic [ID_W:0]   cand;

  // Rotating search: first pending requester at or above the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end else begin
        cand = cand;
      end
      if (!sel_found && req[cand[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[ID_W-1:0];
      end else begin
        sel_found = sel_found;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    gnt         = '0;
    ready       = 1'b0;
    lfsr_cen    = 1'b0;
    lfsr_wen    = 1'b0;
    lfsr_din    = 5'b00000;
    if (!rst) begin
      state_d = S_INIT_WR;
    end else begin
      case (state_q)
        S_INIT_WR: begin
          lfsr_cen = 1'b1;
          lfsr_wen = 1'b1;
          lfsr_din = SEED_INIT;
          wcnt_d   = 8'd0;
          state_d  = (WARMUP > 0) ? S_WARMUP : S_RUN;
        end
        S_WARMUP: begin
          lfsr_cen = 1'b1;
          wcnt_d   = wcnt_q + 8'd1;
          if (wcnt_q == 8'(WARMUP - 1)) begin
            state_d = S_RUN;
          end else begin
            state_d = S_WARMUP;
          end
        end
        S_RUN: begin
          ready = 1'b1;
          if (sel_found) begin
            lfsr_cen    = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_id_d    = sel_idx;
            ptr_d       = (sel_idx == ID_W'(NREQ - 1)) ? '0 : sel_idx + ID_W'(1);
            // Constant-indexed mux keeps the seed/wr selection free of variable part-selects.
            for (int k = 0; k < NREQ; k++) begin
              if (sel_idx == ID_W'(k)) begin
                gnt[k]   = 1'b1;
                lfsr_wen = wr[k];
                lfsr_din = wr[k] ? seed[5*k +: 5] : 5'b00000;
              end else begin
                gnt[k] = 1'b0;
              end
            end
          end else begin
            lfsr_cen = 1'b0;
          end
        end
        default: begin
          state_d = S_INIT_WR;
        end
      endcase
    end
  end

  // State, counter, pointer and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_INIT_WR;
      wcnt_q      <= 8'd0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = lfsr_dout;
  assign lfsr_rst  = ~rst;

endmodule

// File: tb/tb_lfsr16_arbiter.sv
// Scoreboard bench for lfsr16_arbiter with a behavioural lfsr16 attached to each instance.
// Main instance uses WARMUP=3; a second instance uses WARMUP=0.
module tb_lfsr16_arbiter;

  logic        clk = 1'b0;
  logic        rst, rstb;
  logic [3:0]  req, wr, reqb, wrb;
  logic [19:0] seed, seedb;
  logic [3:0]  gnt, gntb;
  logic        ready, readyb, rsp_valid, rsp_validb;
  logic [1:0]  rsp_id, rsp_idb;
  logic [4:0]  rsp_data, rsp_datab;
  logic        lfsr_rst, lfsr_cen, lfsr_wen, lfsr_rstb, lfsr_cenb, lfsr_wenb;
  logic [4:0]  lfsr_din, lfsr_dinb, lq, lqb;

  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  lfsr16_arbiter #(.NREQ(4), .ID_W(2), .SEED_INIT(5'b10000), .WARMUP(3)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .seed(seed), .gnt(gnt), .ready(ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .lfsr_rst(lfsr_rst),
    .lfsr_cen(lfsr_cen), .lfsr_wen(lfsr_wen), .lfsr_din(lfsr_din), .lfsr_dout(lq));

  lfsr16_arbiter #(.NREQ(4), .ID_W(2), .SEED_INIT(5'b10000), .WARMUP(0)) dut_b (
    .clk(clk), .rst(rstb), .req(reqb), .wr(wrb), .seed(seedb), .gnt(gntb), .ready(readyb),
    .rsp_valid(rsp_validb), .rsp_id(rsp_idb), .rsp_data(rsp_datab), .lfsr_rst(lfsr_rstb),
    .lfsr_cen(lfsr_cenb), .lfsr_wen(lfsr_wenb), .lfsr_din(lfsr_dinb), .lfsr_dout(lqb));

  // lfsr16 model: shift left, feedback from bits 4,3,1 plus the all-zero correction bit.
  always @(posedge clk) begin
    if (lfsr_rst) lq <= 5'b00000;
    else if (lfsr_cen) lq <= lfsr_wen ? lfsr_din : {lq[3:0], lq[4] ^ lq[3] ^ lq[1] ^ (lq[4:1] == 4'b0000)};
  end

  always @(posedge clk) begin
    if (lfsr_rstb) lqb <= 5'b00000;
    else if (lfsr_cenb) lqb <= lfsr_wenb ? lfsr_dinb : {lqb[3:0], lqb[4] ^ lqb[3] ^ lqb[1] ^ (lqb[4:1] == 4'b0000)};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented response is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data %b with empty scoreboard", rsp_id, rsp_data);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, e[6:5]});
        chk("rsp_data", {27'd0, rsp_data}, {27'd0, e[4:0]});
      end
    end
  end

  task automatic op(input logic [3:0] r, input logic [3:0] w, input logic [19:0] s,
                    input logic [3:0] eg, input logic [1:0] eid, input logic [4:0] ed);
    req = r; wr = w; seed = s;
    @(negedge clk);
    chk("ready_run", {31'd0, ready}, 32'd1);
    chk("gnt", {28'd0, gnt}, {28'd0, eg});
    if (eg != 4'b0000) exp_q.push_back({eid, ed});
    else chk("cen_idle", {31'd0, lfsr_cen}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rstb = 1'b0;
    req = 4'b0000; wr = 4'b0000; seed = 20'd0;
    reqb = 4'b0000; wrb = 4'b0000; seedb = 20'd0;

    @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_lfsr_rst", {31'd0, lfsr_rst}, 32'd1);
    chk("rst_cen", {31'd0, lfsr_cen}, 32'd0);
    chk("rst_wen", {31'd0, lfsr_wen}, 32'd0);
    chk("rst_din", {27'd0, lfsr_din}, 32'd0);
    @(posedge clk); #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // INIT_WR cycle
    @(negedge clk);
    chk("init_cen", {31'd0, lfsr_cen}, 32'd1);
    chk("init_wen", {31'd0, lfsr_wen}, 32'd1);
    chk("init_din", {27'd0, lfsr_din}, {27'd0, 5'b10000});
    chk("init_ready", {31'd0, ready}, 32'd0);
    chk("init_lfsr_rst", {31'd0, lfsr_rst}, 32'd0);
    @(posedge clk); #1;

    // WARMUP cycles with req0 already pending
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("warm_cen", {31'd0, lfsr_cen}, 32'd1);
      chk("warm_wen", {31'd0, lfsr_wen}, 32'd0);
      chk("warm_ready", {31'd0, ready}, 32'd0);
      chk("warm_gnt", {28'd0, gnt}, 32'd0);
      @(posedge clk); #1;
    end
    chk("warm_dout", {27'd0, lq}, {27'd0, 5'b00111});

    op(4'b0001, 4'b0000, 20'd0, 4'b0001, 2'd0, 5'b01111);
    op(4'b1111, 4'b0000, 20'd0, 4'b0010, 2'd1, 5'b11110);
    op(4'b1111, 4'b0000, 20'd0, 4'b0100, 2'd2, 5'b11101);
    op(4'b1111, 4'b0000, 20'd0, 4'b1000, 2'd3, 5'b11010);
    op(4'b1111, 4'b0000, 20'd0, 4'b0001, 2'd0, 5'b10101);
    op(4'b1111, 4'b0000, 20'd0, 4'b0010, 2'd1, 5'b01011);
    op(4'b0100, 4'b0100, {5'b00000, 5'b11001, 5'b00000, 5'b00000}, 4'b0100, 2'd2, 5'b11001);
    op(4'b0001, 4'b0000, 20'd0, 4'b0001, 2'd0, 5'b10010);
    op(4'b0010, 4'b0010, 20'd0, 4'b0010, 2'd1, 5'b00000);
    op(4'b0010, 4'b0000, 20'd0, 4'b0010, 2'd1, 5'b00001);
    op(4'b1001, 4'b0000, 20'd0, 4'b1000, 2'd3, 5'b00011);
    op(4'b1001, 4'b0000, 20'd0, 4'b0001, 2'd0, 5'b00111);
    op(4'b0000, 4'b0000, 20'd0, 4'b0000, 2'd0, 5'b00000);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset mid-operation
    op(4'b1111, 4'b0000, 20'd0, 4'b0010, 2'd1, 5'b01111);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_lfsr_rst", {31'd0, lfsr_rst}, 32'd1);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rewarm_gnt", {28'd0, gnt}, 32'd0);
      chk("rewarm_ready", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;
    end
    op(4'b1111, 4'b0000, 20'd0, 4'b0001, 2'd0, 5'b01111);
    req = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // WARMUP = 0 instance
    rstb = 1'b1;
    @(negedge clk);
    chk("w0_init_ready", {31'd0, readyb}, 32'd0);
    chk("w0_init_cen", {31'd0, lfsr_cenb}, 32'd1);
    chk("w0_init_wen", {31'd0, lfsr_wenb}, 32'd1);
    @(posedge clk); #1;
    reqb = 4'b0001;
    @(negedge clk);
    chk("w0_ready", {31'd0, readyb}, 32'd1);
    chk("w0_gnt", {28'd0, gntb}, 32'd1);
    @(posedge clk); #1;
    reqb = 4'b0000;
    @(negedge clk);
    chk("w0_rsp_valid", {31'd0, rsp_validb}, 32'd1);
    chk("w0_rsp_id", {30'd0, rsp_idb}, 32'd0);
    chk("w0_rsp_data", {27'd0, rsp_datab}, {27'd0, 5'b00001});
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
